// File: rtl/servo_frame_scheduler_if.sv
// servo_frame_scheduler_if: command handshake carrying a channel index and target position
interface servo_frame_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_chan;
    logic [17:0] cmd_pos;
    modport master (output cmd_valid, cmd_chan, cmd_pos, input cmd_ready);
    modport slave (input cmd_valid, cmd_chan, cmd_pos, output cmd_ready);
endinterface

// File: rtl/servo_frame_scheduler.sv
// servo_frame_scheduler: shared-frame servo PWM whose per-channel widths slew toward commanded targets once per frame
module servo_frame_scheduler #(
    parameter int CHANNELS  = 4,
    parameter int PERIOD    = 2000000,
    parameter int MIN_WIDTH = 70000,
    parameter int MAX_POS   = 150000,
    parameter int STEP      = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    servo_frame_scheduler_if.slave  cmd,
    output logic [CHANNELS-1:0]     servo,
    output logic [CHANNELS-1:0]     busy,
    output logic                    frame_tick
);
    localparam logic [20:0] LAST = 21'(PERIOD - 1);
    localparam logic [20:0] MINW = 21'(MIN_WIDTH);
    localparam logic [17:0] MAXP = 18'(MAX_POS);
    localparam logic [17:0] STP  = 18'(STEP);
    logic [20:0] count, count_nxt;
    logic [17:0] target [CHANNELS];
    logic [17:0] live [CHANNELS];
    logic [17:0] live_nxt [CHANNELS];
    logic [17:0] pos_clamped;
    logic        upd, accept;
    always_comb begin
        upd = count == LAST;
        count_nxt = upd ? '0 : count + 21'd1;
        accept = cmd.cmd_valid && cmd.cmd_ready;
        pos_clamped = cmd.cmd_pos > MAXP ? MAXP : cmd.cmd_pos;
        for (int i = 0; i < CHANNELS; i++)
            live_nxt[i] = target[i] > live[i] ? (target[i] - live[i] > STP ? live[i] + STP : target[i])
                                              : (live[i] - target[i] > STP ? live[i] - STP : target[i]);
    end
    // ready is registered against the next count so it is already low throughout the update cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            cmd.cmd_ready <= 1'b0;
            servo <= '0;
            busy <= '0;
            frame_tick <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                live[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            cmd.cmd_ready <= count_nxt != LAST;
            frame_tick <= upd;
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept && 32'(cmd.cmd_chan) == i)
                    target[i] <= pos_clamped;
                if (upd)
                    live[i] <= live_nxt[i];
                servo[i] <= count < MINW + 21'(live[i]);
                busy[i] <= live[i] != target[i];
            end
        end
    end
endmodule

// File: tb/tb_servo_frame_scheduler.sv
// tb_servo_frame_scheduler: randomized commands checked against a frame-level reference model via a width scoreboard
module tb_servo_frame_scheduler;
    localparam int CH = 3, PER = 1000, MINW = 70, MAXP = 150, STEP = 20;
    logic clock = 0, reset = 1;
    logic [CH-1:0] servo, busy;
    logic frame_tick;
    servo_frame_scheduler_if cmd();
    servo_frame_scheduler #(.CHANNELS(CH), .PERIOD(PER), .MIN_WIDTH(MINW), .MAX_POS(MAXP), .STEP(STEP)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .servo(servo), .busy(busy), .frame_tick(frame_tick));
    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int m_cnt = 0;
    int m_target [CH];
    int m_live [CH];
    int run [CH];
    int exp_w [CH][$];
    bit e_ready = 0, e_tick = 0, m_acc = 0, m_rst = 1, started = 0;
    bit [CH-1:0] e_busy = '0;

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // reference model: frame position, targets and live positions, evaluated at each rising edge
    initial forever begin
        @(posedge clock);
        started = 1;
        m_acc = 0;
        if (reset) begin
            m_rst = 1; m_cnt = 0; e_ready = 0; e_tick = 0; e_busy = '0;
            for (int c = 0; c < CH; c++) begin
                m_target[c] = 0; m_live[c] = 0;
                exp_w[c].delete();
                exp_w[c].push_back(MINW);
            end
        end else begin
            m_rst = 0;
            m_acc = cmd.cmd_valid && e_ready;
            for (int c = 0; c < CH; c++) e_busy[c] = m_live[c] != m_target[c];
            e_tick = m_cnt == PER - 1;
            if (m_acc && cmd.cmd_chan < CH)
                m_target[cmd.cmd_chan] = cmd.cmd_pos > MAXP ? MAXP : int'(cmd.cmd_pos);
            if (e_tick)
                for (int c = 0; c < CH; c++) begin
                    int d;
                    d = m_target[c] - m_live[c];
                    m_live[c] += d > STEP ? STEP : (d < -STEP ? -STEP : d);
                    check($sformatf("pulse_seen%0d", c), exp_w[c].size(), 0);
                    exp_w[c].push_back(MINW + m_live[c]);
                end
            m_cnt = e_tick ? 0 : m_cnt + 1;
            e_ready = m_cnt != PER - 1;
        end
    end

    // monitor: per-cycle flag checks and pulse-width scoreboard pops
    initial forever begin
        @(negedge clock);
        if (started) begin
            check("cmd_ready", cmd.cmd_ready, e_ready);
            check("busy", busy, e_busy);
            check("frame_tick", frame_tick, e_tick);
            if (m_rst) begin
                check("servo_reset", servo, 0);
                for (int c = 0; c < CH; c++) run[c] = 0;
            end else
                for (int c = 0; c < CH; c++)
                    if (servo[c]) run[c]++;
                    else if (run[c] > 0) begin
                        if (exp_w[c].size() == 0) check($sformatf("width_unexpected%0d", c), run[c], -1);
                        else check($sformatf("width%0d", c), run[c], exp_w[c].pop_front());
                        run[c] = 0;
                    end
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(int ch, int pos);
        cmd.cmd_valid = 1;
        cmd.cmd_chan = 2'(ch);
        cmd.cmd_pos = 18'(pos);
        for (int k = 0; k < 3 * PER; k++) begin
            @(negedge clock);
            if (m_acc) begin
                cmd.cmd_valid = 0;
                return;
            end
        end
        check("accept_timeout", 0, 1);
        cmd.cmd_valid = 0;
    endtask

    initial begin
        cmd.cmd_valid = 0; cmd.cmd_chan = 0; cmd.cmd_pos = 0;
        reset = 1;
        wait_cycles(5);
        reset = 0;
        wait_cycles(2 * PER);
        send(0, 100);
        wait_cycles(6 * PER);
        send(1, 200000);
        wait_cycles(9 * PER);
        send(3, 50);
        wait_cycles(PER);
        for (int k = 0; k < PER + 1; k++) begin
            @(negedge clock);
            if (m_cnt == PER - 1) break;
        end
        send(0, 10);
        wait_cycles(6 * PER);
        send(2, 150);
        wait_cycles(2 * PER + 300);
        reset = 1;
        wait_cycles(3);
        reset = 0;
        wait_cycles(2 * PER);
        repeat (30) begin
            send($urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 262143) : $urandom_range(0, MAXP));
            wait_cycles(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 800));
        end
        wait_cycles(8 * PER);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
